// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer: walks a 32-character message buffer onto a 2x16 LCD.
// Each LCD operation is handed to an external timer IP as a one-cycle strobe
// plus function/operand, and the sequencer waits for that IP's completion.
// A bounded wait turns a stuck LCD into a sticky error instead of a hang.
module lcd_msg_sequencer #(
  parameter int SIZE_DATA   = 8,
  parameter int SIZE_FUNC   = 4,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_reinit,
  output logic [4:0]           o_rd_addr,
  input  logic [SIZE_DATA-1:0] i_rd_data,
  output logic                 o_en_lcd,
  output logic [SIZE_FUNC-1:0] o_func,
  output logic [SIZE_DATA-1:0] o_data,
  input  logic                 i_done_lcd,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_REQ,
    INIT_WAIT,
    CUR_REQ,
    CUR_WAIT,
    RD,
    DAT_REQ,
    DAT_WAIT,
    FINISH
  } state_t;

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   init_flag;
  logic [4:0]             idx;
  logic                   line;
  logic [CW-1:0]          wait_cnt;
  logic                   error_q;
  logic [SIZE_DATA-1:0]   data_q;

  logic                   is_wait;
  logic                   wait_done;
  logic                   wait_tout;

  // The completion input is only trusted after the first WAIT cycle, and it
  // beats the timeout when both land on the last allowed cycle.
  assign is_wait   = (state == INIT_WAIT) || (state == CUR_WAIT) || (state == DAT_WAIT);
  assign wait_done = is_wait && (wait_cnt != '0) && i_done_lcd;
  assign wait_tout = is_wait && !wait_done && (wait_cnt == WAIT_LAST);

  // State register; reset always wins over start and completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and all LCD-facing outputs, derived from the current state.
  always_comb begin
    state_nxt = state;
    o_en_lcd  = 1'b0;
    o_func    = '0;
    o_data    = '0;
    o_busy    = (state != IDLE);
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = (!init_flag || i_reinit) ? INIT_REQ : CUR_REQ;
      end
      INIT_REQ: begin
        o_en_lcd  = 1'b1;
        state_nxt = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (wait_done)      state_nxt = CUR_REQ;
        else if (wait_tout) state_nxt = IDLE;
      end
      CUR_REQ: begin
        o_en_lcd  = 1'b1;
        o_func    = SIZE_FUNC'(1);
        o_data    = SIZE_DATA'({line, 4'h0});
        state_nxt = CUR_WAIT;
      end
      CUR_WAIT: begin
        o_func = SIZE_FUNC'(1);
        o_data = SIZE_DATA'({line, 4'h0});
        if (wait_done)      state_nxt = RD;
        else if (wait_tout) state_nxt = IDLE;
      end
      RD: begin
        state_nxt = DAT_REQ;
      end
      DAT_REQ: begin
        o_en_lcd  = 1'b1;
        o_func    = SIZE_FUNC'(3);
        o_data    = i_rd_data;
        state_nxt = DAT_WAIT;
      end
      DAT_WAIT: begin
        o_func = SIZE_FUNC'(3);
        o_data = data_q;
        if (wait_done) begin
          if (idx == 5'd31)      state_nxt = FINISH;
          else if (idx == 5'd15) state_nxt = CUR_REQ;
          else                   state_nxt = RD;
        end else if (wait_tout) begin
          state_nxt = IDLE;
        end
      end
      FINISH: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence bookkeeping: char index, line, wait counter, init/error flags and
  // the held copy of the character being written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      init_flag <= 1'b0;
      idx       <= '0;
      line      <= 1'b0;
      wait_cnt  <= '0;
      error_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      wait_cnt <= is_wait ? wait_cnt + CW'(1) : '0;
      if (state == DAT_REQ) data_q <= i_rd_data;
      case (state)
        IDLE: begin
          if (i_start) begin
            error_q <= 1'b0;
            idx     <= '0;
            line    <= 1'b0;
          end
        end
        INIT_WAIT: begin
          if (wait_done) begin
            init_flag <= 1'b1;
            line      <= 1'b0;
          end
        end
        DAT_WAIT: begin
          if (wait_done) begin
            idx <= idx + 5'd1;
            if (idx == 5'd15) line <= 1'b1;
          end
        end
        FINISH: begin
          idx  <= '0;
          line <= 1'b0;
        end
        default: ;
      endcase
      if (wait_tout) begin
        error_q   <= 1'b1;
        init_flag <= 1'b0;
        idx       <= '0;
        line      <= 1'b0;
      end
    end
  end

  assign o_rd_addr = idx;
  assign o_error   = error_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Bench for lcd_msg_sequencer: a synchronous-read message buffer, an LCD IP
// responder with random latency, and a transaction log compared against an
// expected transaction list built from the message contents.
module tb_lcd_msg_sequencer;

  localparam int SD = 8;
  localparam int SF = 4;
  localparam int TO = 100;

  typedef logic [SF+SD-1:0] tx_t;
  typedef tx_t tx_list_t[$];

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_reinit;
  logic [4:0]    o_rd_addr;
  logic [SD-1:0] i_rd_data;
  logic          o_en_lcd;
  logic [SF-1:0] o_func;
  logic [SD-1:0] o_data;
  logic          i_done_lcd;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  lcd_msg_sequencer #(
    .SIZE_DATA  (SD),
    .SIZE_FUNC  (SF),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_reinit  (i_reinit),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_en_lcd  (o_en_lcd),
    .o_func    (o_func),
    .o_data    (o_data),
    .i_done_lcd(i_done_lcd),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_error   (o_error)
  );

  always #5 i_clk = ~i_clk;

  // Message buffer with one cycle of read latency.
  logic [SD-1:0] mem [32];
  always @(posedge i_clk) i_rd_data <= mem[o_rd_addr];

  int  vectors    = 0;
  int  miscompares = 0;
  tx_t txq[$];
  int  done_cnt   = 0;
  bit  exp_init   = 0;
  bit  cur_withhold = 0;
  bit  stretch_done = 0;
  int  cur_delay  = 0;

  // Reference: the transactions a run must produce for the current buffer.
  function automatic tx_list_t build_expected(input bit with_init);
    tx_list_t q;
    q = {};
    if (with_init) q.push_back({4'd0, 8'h00});
    q.push_back({4'd1, 8'h00});
    for (int i = 0; i < 16; i++) q.push_back({4'd3, mem[i]});
    q.push_back({4'd1, 8'h10});
    for (int i = 16; i < 32; i++) q.push_back({4'd3, mem[i]});
    return q;
  endfunction

  // Transaction log: every strobe and every done pulse seen by the LCD side.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_en_lcd === 1'b1) txq.push_back({o_func, o_data});
      if (o_done === 1'b1) done_cnt++;
    end
  end

  // LCD IP model: answers each strobe after a delay, and checks the operand
  // is still held when it answers.
  int  resp_cnt = 0;
  tx_t resp_held;
  bit  resp_stretch = 0;
  initial begin
    i_done_lcd = 1'b0;
    forever begin
      @(negedge i_clk);
      if (resp_stretch) resp_stretch = 0;
      else              i_done_lcd = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          if (o_busy === 1'b1) begin
            vectors++;
            if ({o_func, o_data} !== resp_held) begin
              miscompares++;
              $display("[TB] FAIL hold_stable got %h want %h", {o_func, o_data}, resp_held);
            end
          end
          i_done_lcd   = 1'b1;
          resp_stretch = stretch_done;
        end
      end
      if (o_en_lcd === 1'b1) begin
        resp_held = {o_func, o_data};
        resp_cnt  = $urandom_range(2, 6);
        if (o_func == 4'd1 && cur_delay != 0) resp_cnt = cur_delay;
        if (o_func == 4'd1 && cur_withhold)   resp_cnt = 0;
      end
    end
  end

  task automatic do_run(input bit reinit, input bit noise, output bit hung);
    int n;
    txq.delete();
    done_cnt = 0;
    hung = 0;
    n = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_reinit = reinit;
    @(negedge i_clk);
    i_start = 1'b0;
    i_reinit = 1'b0;
    while (o_busy === 1'b1 && n < 3000) begin
      if (noise) i_start = ($urandom_range(0, 3) == 0);
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    if (n >= 3000) hung = 1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b1;
    i_reinit = 1'b0;
    repeat (3) @(negedge i_clk);
    vectors++; if (o_en_lcd !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en got %b want 0", o_en_lcd); end
    vectors++; if (o_func !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_func got %h want 0", o_func); end
    vectors++; if (o_data !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", o_data); end
    vectors++; if (o_rd_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_addr got %h want 0", o_rd_addr); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
    vectors++; if (o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", o_done); end
    vectors++; if (o_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error got %b want 0", o_error); end
    i_rst = 1'b0;
    i_start = 1'b0;
    exp_init = 0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_first_start();
    tx_list_t exp;
    bit hung;
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h30 + i);
    exp = build_expected(!exp_init);
    do_run(1'b0, 1'b0, hung);
    exp_init = 1;
    vectors++; if (hung) begin miscompares++; $display("[TB] FAIL first_hang got busy want idle"); end
    vectors++; if (txq.size() !== 35) begin miscompares++; $display("[TB] FAIL first_count got %0d want 35", txq.size()); end
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("[TB] FAIL first_tx%0d got %h want %h", i, txq[i], exp[i]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL first_done got %0d want 1", done_cnt); end
    vectors++; if (o_error !== 1'b0) begin miscompares++; $display("[TB] FAIL first_error got %b want 0", o_error); end
  endtask

  task automatic test_second_start();
    tx_list_t exp;
    bit hung;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    exp = build_expected(!exp_init);
    do_run(1'b0, 1'b0, hung);
    vectors++; if (hung) begin miscompares++; $display("[TB] FAIL second_hang got busy want idle"); end
    vectors++; if (txq.size() !== 34) begin miscompares++; $display("[TB] FAIL second_count got %0d want 34", txq.size()); end
    vectors++;
    if (txq.size() == 0 || txq[0] !== tx_t'({4'd1, 8'h00})) begin
      miscompares++; $display("[TB] FAIL second_first got %h want 100", (txq.size() == 0) ? tx_t'('x) : txq[0]);
    end
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("[TB] FAIL second_tx%0d got %h want %h", i, txq[i], exp[i]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL second_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reinit();
    tx_list_t exp;
    bit hung;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    exp = build_expected(1'b1);
    do_run(1'b1, 1'b0, hung);
    exp_init = 1;
    vectors++; if (hung) begin miscompares++; $display("[TB] FAIL reinit_hang got busy want idle"); end
    vectors++; if (txq.size() !== 35) begin miscompares++; $display("[TB] FAIL reinit_count got %0d want 35", txq.size()); end
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("[TB] FAIL reinit_tx%0d got %h want %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_ignored_inputs();
    tx_list_t exp;
    bit hung;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    exp = build_expected(!exp_init);
    stretch_done = 1;
    do_run(1'b0, 1'b1, hung);
    stretch_done = 0;
    vectors++; if (hung) begin miscompares++; $display("[TB] FAIL ignored_hang got busy want idle"); end
    vectors++; if (txq.size() !== 34) begin miscompares++; $display("[TB] FAIL ignored_count got %0d want 34", txq.size()); end
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("[TB] FAIL ignored_tx%0d got %h want %h", i, txq[i], exp[i]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL ignored_done got %0d want 1", done_cnt); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ignored_idle got %b want 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    tx_list_t exp;
    bit hung;
    int n;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    txq.delete();
    n = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    while (txq.size() < 9 && n < 500) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    vectors++; if (n >= 500) begin miscompares++; $display("[TB] FAIL mid_reach got %0d strobes want 9", txq.size()); end
    @(negedge i_clk);
    i_rst = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_start = 1'b0;
    vectors++; if (o_en_lcd !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_en got %b want 0", o_en_lcd); end
    vectors++; if (o_func !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_func got %h want 0", o_func); end
    vectors++; if (o_data !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_data got %h want 0", o_data); end
    vectors++; if (o_rd_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL mid_addr got %h want 0", o_rd_addr); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy got %b want 0", o_busy); end
    vectors++; if (o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_done got %b want 0", o_done); end
    vectors++; if (o_error !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_error got %b want 0", o_error); end
    exp_init = 0;
    repeat (10) @(negedge i_clk);
    exp = build_expected(!exp_init);
    do_run(1'b0, 1'b0, hung);
    exp_init = 1;
    vectors++; if (txq.size() !== 35) begin miscompares++; $display("[TB] FAIL mid_after_count got %0d want 35", txq.size()); end
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("[TB] FAIL mid_after_tx%0d got %h want %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_timeout();
    tx_list_t exp;
    bit hung;
    cur_withhold = 1;
    txq.delete();
    done_cnt = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    vectors++;
    if (o_en_lcd !== 1'b1 || o_func !== 4'd1) begin
      miscompares++; $display("[TB] FAIL to_strobe got en=%b func=%h want en=1 func=1", o_en_lcd, o_func);
    end
    repeat (TO) @(negedge i_clk);
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL to_last_busy got %b want 1", o_busy); end
    vectors++; if (o_error !== 1'b0) begin miscompares++; $display("[TB] FAIL to_last_error got %b want 0", o_error); end
    @(negedge i_clk);
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL to_busy got %b want 0", o_busy); end
    vectors++; if (o_error !== 1'b1) begin miscompares++; $display("[TB] FAIL to_error got %b want 1", o_error); end
    exp_init = 0;
    cur_withhold = 0;
    repeat (5) @(negedge i_clk);
    vectors++; if (o_error !== 1'b1) begin miscompares++; $display("[TB] FAIL to_sticky got %b want 1", o_error); end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("[TB] FAIL to_nodone got %0d want 0", done_cnt); end
    vectors++; if (txq.size() !== 1) begin miscompares++; $display("[TB] FAIL to_count got %0d want 1", txq.size()); end
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    exp = build_expected(!exp_init);
    do_run(1'b0, 1'b0, hung);
    exp_init = 1;
    vectors++; if (txq.size() !== 35) begin miscompares++; $display("[TB] FAIL to_after_count got %0d want 35", txq.size()); end
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      vectors++;
      if (txq[i] !== exp[i]) begin miscompares++; $display("[TB] FAIL to_after_tx%0d got %h want %h", i, txq[i], exp[i]); end
    end
    vectors++; if (o_error !== 1'b0) begin miscompares++; $display("[TB] FAIL to_cleared got %b want 0", o_error); end
  endtask

  task automatic test_timeout_boundary();
    bit hung;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    cur_delay = TO;
    do_run(1'b0, 1'b0, hung);
    vectors++; if (o_error !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_win_error got %b want 0", o_error); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL edge_win_done got %0d want 1", done_cnt); end
    vectors++; if (txq.size() !== 34) begin miscompares++; $display("[TB] FAIL edge_win_count got %0d want 34", txq.size()); end
    cur_delay = 1;
    do_run(1'b0, 1'b0, hung);
    cur_delay = 0;
    exp_init = 0;
    vectors++; if (hung) begin miscompares++; $display("[TB] FAIL edge_early_hang got busy want idle"); end
    vectors++; if (o_error !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_early_error got %b want 1", o_error); end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("[TB] FAIL edge_early_done got %0d want 0", done_cnt); end
    vectors++; if (txq.size() !== 1) begin miscompares++; $display("[TB] FAIL edge_early_count got %0d want 1", txq.size()); end
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_reinit = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    $display("[TB] starting lcd_msg_sequencer bench");
    test_reset();
    test_first_start();
    test_second_start();
    test_reinit();
    test_ignored_inputs();
    test_reset_mid();
    test_timeout();
    test_timeout_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_msg_sequencer.md
LCD_MSG_SEQUENCER -- requirements
Module: lcd_msg_sequencer

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, meaning width of the LCD data/command byte.
REQ-002 SHALL have parameter SIZE_FUNC, default 4, meaning width of the LCD function code.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5_000_000, meaning the maximum number of clocks to wait for i_done_lcd per transaction.
REQ-004 SHALL have port i_clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit, meaning the synchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1 bit, meaning request to display the 32-char message buffer.
REQ-007 SHALL have port i_reinit, input, 1 bit, meaning force an INIT transaction on the next accepted i_start.
REQ-008 SHALL have port o_rd_addr, output, 5 bits, meaning the message buffer read address.
REQ-009 SHALL have port i_rd_data, input, SIZE_DATA bits, meaning message buffer read data, valid 1 cycle after o_rd_addr.
REQ-010 SHALL have port o_en_lcd, output, 1 bit, meaning the 1-cycle transaction strobe to the LCD timer IP.
REQ-011 SHALL have port o_func, output, SIZE_FUNC bits, meaning the function code (0 = init, 1 = set cursor, 2 = command, 3 = data).
REQ-012 SHALL have port o_data, output, SIZE_DATA bits, meaning the operand of the transaction.
REQ-013 SHALL have port i_done_lcd, input, 1 bit, meaning the LCD IP completion indication.
REQ-014 SHALL have port o_busy, output, 1 bit, meaning a sequence is in progress.
REQ-015 SHALL have port o_done, output, 1 bit, meaning a 1-cycle pulse on successful completion.
REQ-016 SHALL have port o_error, output, 1 bit, meaning a sticky timeout flag, cleared by the next accepted i_start.

Function
REQ-017 SHALL implement the states IDLE, INIT_REQ, INIT_WAIT, CUR_REQ, CUR_WAIT, RD, DAT_REQ, DAT_WAIT and FINISH.
REQ-018 SHALL accept i_start only in IDLE; i_start in any other state is ignored.
REQ-019 SHALL go to INIT_REQ on accepted i_start if the init flag is clear or i_reinit=1; otherwise SHALL go to CUR_REQ with line 0.
REQ-020 SHALL assert o_busy from the cycle after accepted i_start through FINISH inclusive.
REQ-021 SHALL assert o_en_lcd for exactly 1 cycle in each *_REQ state, with o_func/o_data driven and held stable until the matching *_WAIT state exits.
REQ-022 SHALL drive o_en_lcd high 1 cycle after accepted i_start (INIT_REQ or CUR_REQ).
REQ-023 SHALL drive INIT_REQ with o_func=0, o_data=0; on i_done_lcd in INIT_WAIT it SHALL set the init flag and go to CUR_REQ with line 0.
REQ-024 SHALL drive CUR_REQ with o_func=1 and o_data={3'b000, line, 4'h0}, giving 0x00 for line 0 and 0x10 for line 1.
REQ-025 SHALL go from CUR_WAIT, on i_done_lcd, to RD.
REQ-026 SHALL drive o_rd_addr = char index (0..31) in RD, then go to DAT_REQ.
REQ-027 SHALL drive DAT_REQ with o_func=3 and o_data=i_rd_data captured on entry to DAT_REQ.
REQ-028 SHALL increment the char index on i_done_lcd in DAT_WAIT, then:
- index 15 -> 16: go to CUR_REQ with line 1;
- index 31: go to FINISH;
- otherwise: go to RD.
REQ-029 SHALL pulse o_done for 1 cycle in FINISH, then return to IDLE with the index and line cleared.
REQ-030 SHALL sample i_done_lcd only in *_WAIT states, and not in the cycle they are entered; i_done_lcd elsewhere is ignored.
REQ-031 SHALL use a wait counter cleared on entering each *_WAIT state; reaching TIMEOUT_CYC-1 without i_done_lcd SHALL:
- set o_error;
- clear the init flag;
- return to IDLE with o_busy low;
- not pulse o_done.
REQ-032 SHALL let i_done_lcd win if it coincides with the timeout cycle.
REQ-033 SHALL keep o_en_lcd low in all non-*_REQ states.

Reset
REQ-034 SHALL, on i_rst=1 at a clock edge in any state (including mid-sequence), next cycle hold:
- state = IDLE;
- o_en_lcd=0, o_func=0, o_data=0, o_rd_addr=0;
- o_busy=0, o_done=0, o_error=0;
- init flag, index, line and wait counter = 0.
REQ-035 SHALL give i_rst priority over i_start and i_done_lcd in the same cycle.

Verification
REQ-036 SHALL cover first start: reset, buffer "0123...", i_start -> one func 0 transaction, cursor o_data=0x00, 16 func 3 writes of 0x30.., cursor 0x10, 16 more writes, o_done 1 pulse, exactly 35 o_en_lcd pulses.
REQ-037 SHALL cover second start without i_reinit -> no func 0 transaction, exactly 34 o_en_lcd pulses, first strobe is o_func=1, o_data=0x00.
REQ-038 SHALL cover i_start with i_reinit=1 after a completed run -> a func 0 transaction precedes the cursor transaction.
REQ-039 SHALL cover timeout: TIMEOUT_CYC=100, i_done_lcd withheld in CUR_WAIT -> o_error=1 and o_busy=0 after 100 wait cycles, no o_done, and the next i_start begins with func 0.
REQ-040 SHALL cover reset mid-operation: i_rst asserted during DAT_WAIT at index 7 -> all outputs 0 next cycle, and the next i_start issues func 0.
REQ-041 SHALL cover ignored inputs: i_start pulsed while busy and i_done_lcd pulsed in RD -> no extra transaction, write count unchanged.
